risc_fetch_unit: RTL and testbench
==================================

Name: risc_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the RISC execute/write-back core.
- Owns the program counter, issues word reads to instruction memory (fixed 1-cycle latency) and buffers returned words in a small prefetch queue.
- Presents instructions with their PC to execute over a valid/ready handshake.
- Accepts branch redirects from execute and flushes stale prefetches.

Parameters:
WIDTH, 32, instruction/data word width
ADDRSIZE, 12, PC / instruction address width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  read request to instruction memory this cycle
imem_addr  output  ADDRSIZE  read address, valid when imem_req=1
imem_rdata  input  WIDTH  read data, valid the cycle after the request
redirect  input  1  branch taken, one-cycle pulse from execute
redirect_pc  input  ADDRSIZE  branch target, sampled when redirect=1
halt  input  1  level; stop issuing new fetches while high
ir_valid  output  1  ir/ir_pc hold a valid instruction
ir  output  WIDTH  instruction word at queue head
ir_pc  output  ADDRSIZE  address of ir
ir_ready  input  1  execute accepts ir this cycle
fetch_pc  output  ADDRSIZE  next address to be requested (debug)

Behaviour:
- Interface: one clock (clk); reset is synchronous, active-high.
- Reset values: pc=RESET_PC; queue empty; in-flight flag=0; state=RUN; imem_req=0; imem_addr=RESET_PC; ir_valid=0; ir=0; ir_pc=0; fetch_pc=RESET_PC. A reset mid-operation discards the queue and any in-flight read. The response to a read issued in the reset cycle is never pushed.
- States:
  - RUN: normal fetch.
  - FLUSH: the single cycle following a redirect.
  - STOPPED: optional HLT stop; see Optional Feature.
- Issue rule (RUN only): imem_req=1 when halt=0, redirect=0, and (count + inflight) < DEPTH. On issue: imem_addr=pc, pc<=pc+1. Wrap from 2^ADDRSIZE-1 to 0 is silent.
- Response: the cycle after an issue, imem_rdata is pushed with its issue address, unless a redirect or reset occurred in the issue cycle or the response cycle. In those cases the response is dropped (in-flight kill).
- Latency:
  - First request is in the first cycle after reset deasserts.
  - ir_valid rises 2 cycles after that request (issue in cycle N, push at end of N+1, visible in N+2).
  - Steady-state throughput is 1 instruction/cycle with ir_ready=1.
- Handshake: a pop occurs when ir_valid && ir_ready. While ir_valid=1 and ir_ready=0, ir and ir_pc are held stable. A push and a pop in the same cycle leave count unchanged.
- Full: count+inflight==DEPTH blocks issue. No push ever occurs into a full queue.
- Empty: ir_valid=0; ir and ir_pc hold their last values.
- Redirect (any state), in the redirect cycle:
  - queue cleared;
  - in-flight killed;
  - a simultaneous pop is ignored;
  - no request issued;
  - pc<=redirect_pc;
  - state<=FLUSH.
- Redirect, next cycle: ir_valid=0. FLUSH issues at redirect_pc (if halt=0) and goes to RUN.
- Redirect vs. halt: redirect has priority. The pc is still updated while halt=1.
- halt=1: no new issues. An in-flight response is still pushed, and the queue continues to drain. Fetch resumes the cycle after halt falls.

Optional Feature:
Macro FETCH_HLT_STOP_EN.
- Defined: every pushed word is checked for opcode bits [31:28]==4'b1001 (HLT).
  - On push of HLT, state<=STOPPED and issuing stops. The HLT word itself is still queued and delivered.
  - Any response in flight is dropped.
  - pc<=HLT address+1.
  - STOPPED exits only on redirect (to FLUSH) or reset.
- Undefined: no opcode inspection. The STOPPED state does not exist, and fetch continues past HLT.

Test Plan:
1. Reset -> run with ir_ready=1, memory word k = k -> first request at addr 0 in cycle 1 after reset; ir_valid from cycle 3; ir_pc 0,1,2,... one per cycle; fetch_pc increments.
2. Backpressure: ir_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then imem_req=0; ir stays 0 with ir_pc=0; releasing ir_ready delivers pcs 0..3 in order then resumes at 4 without gap or duplicate.
3. Redirect to 0x100 while 3 entries are queued and 1 is in flight, with ir_ready=1 -> next cycle ir_valid=0 and imem_addr=0x100; next valid ir_pc=0x100; no stale pc ever appears.
4. Wrap: RESET_PC=0xFFE -> ir_pc sequence 0xFFE, 0xFFF, 0x000, 0x001.
5. halt asserted for 5 cycles with one request in flight -> that word is delivered; no imem_req during halt; fetch resumes at the next sequential pc the cycle after halt drops.
6. FETCH_HLT_STOP_EN defined, memory[5]=0x90000000 -> instruction at pc 5 is delivered, no further requests; redirect to 0x020 restarts fetch at 0x020. With the macro undefined, pc 6 is fetched normally.

Source files
------------

// File: rtl/risc_fetch_unit.sv
// risc_fetch_unit: instruction fetch stage feeding the execute/write-back core.
// Owns the PC, issues one-word reads to an instruction memory with a fixed
// one-cycle read latency, buffers the returned words in a small prefetch
// queue and hands them to execute together with their address.
//
// Handshake: an instruction moves to execute in every cycle where
// ir_valid && ir_ready are both high. ir_valid never depends on ir_ready,
// and ir/ir_pc stay stable while ir_valid=1 and ir_ready=0.
//
// Optional build macro FETCH_HLT_STOP_EN: when defined, a fetched word whose
// top opcode nibble is 4'b1001 (HLT) stops further fetching. The HLT word is
// still delivered, and fetching resumes only after a redirect or reset.
module risc_fetch_unit #(
   parameter int WIDTH    = 32,
   parameter int ADDRSIZE = 12,
   parameter int DEPTH    = 4,
   parameter logic [ADDRSIZE-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req,
   output logic [ADDRSIZE-1:0] imem_addr,
   input  logic [WIDTH-1:0]    imem_rdata,
   input  logic                redirect,
   input  logic [ADDRSIZE-1:0] redirect_pc,
   input  logic                halt,
   output logic                ir_valid,
   output logic [WIDTH-1:0]    ir,
   output logic [ADDRSIZE-1:0] ir_pc,
   input  logic                ir_ready,
   output logic [ADDRSIZE-1:0] fetch_pc
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_FLUSH   = 2'd1;
`ifdef FETCH_HLT_STOP_EN
   localparam logic [1:0] ST_STOPPED = 2'd2;
`endif

   // Architectural state
   logic [ADDRSIZE-1:0] pc_q, pc_d;
   logic [1:0]          state_q, state_d;
   logic                inflight_q, inflight_d;
   logic [ADDRSIZE-1:0] inflight_pc_q, inflight_pc_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [WIDTH-1:0]    mem_ir_q [DEPTH];
   logic [WIDTH-1:0]    mem_ir_d [DEPTH];
   logic [ADDRSIZE-1:0] mem_pc_q [DEPTH];
   logic [ADDRSIZE-1:0] mem_pc_d [DEPTH];
   // Last head shown to execute; drives ir/ir_pc while the queue is empty
   logic [WIDTH-1:0]    hold_ir_q, hold_ir_d;
   logic [ADDRSIZE-1:0] hold_pc_q, hold_pc_d;

   // Per-cycle control
   logic                issue;
   logic                push;
   logic                pop;
   logic                hlt_push;
   logic [CNT_W:0]      occ;

   assign ir_valid  = (count_q != '0);
   assign ir        = ir_valid ? mem_ir_q[rd_ptr_q] : hold_ir_q;
   assign ir_pc     = ir_valid ? mem_pc_q[rd_ptr_q] : hold_pc_q;
   assign imem_req  = issue;
   assign imem_addr = pc_q;
   assign fetch_pc  = pc_q;

   // A returning word is kept only if no redirect arrives in its response cycle
   assign push = inflight_q && !redirect;
   // A redirect discards the queue, so a pop in that cycle does not count
   assign pop  = ir_valid && ir_ready && !redirect;

`ifdef FETCH_HLT_STOP_EN
   assign hlt_push = push && (imem_rdata[WIDTH-1 -: 4] == 4'b1001);
`else
   assign hlt_push = 1'b0;
`endif

   // Issue decision: room counts both queued words and the read in flight
   always_comb begin
      occ   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
      issue = 1'b0;
      if (!reset && !redirect && !halt && !hlt_push &&
          (state_q == ST_RUN || state_q == ST_FLUSH) && (occ < DEPTH_C)) begin
         issue = 1'b1;
      end
   end

   // Next-state logic for PC, FSM, in-flight tracking and prefetch queue
   always_comb begin
      pc_d          = pc_q;
      state_d       = state_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      mem_ir_d      = mem_ir_q;
      mem_pc_d      = mem_pc_q;
      hold_ir_d     = hold_ir_q;
      hold_pc_d     = hold_pc_q;

      if (ir_valid) begin
         hold_ir_d = mem_ir_q[rd_ptr_q];
         hold_pc_d = mem_pc_q[rd_ptr_q];
      end

      if (redirect) begin
         // Redirect wins over everything: drop queue and in-flight read
         pc_d       = redirect_pc;
         state_d    = ST_FLUSH;
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         inflight_d    = issue;
         inflight_pc_d = pc_q;
         if (issue) begin
            pc_d = pc_q + 1'b1;
         end
         if (state_q == ST_FLUSH) begin
            state_d = ST_RUN;
         end

         if (push) begin
            mem_ir_d[wr_ptr_q] = imem_rdata;
            mem_pc_d[wr_ptr_q] = inflight_pc_q;
            wr_ptr_d           = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase

`ifdef FETCH_HLT_STOP_EN
         // HLT arrived: park, and restart point is the word after HLT
         if (hlt_push) begin
            state_d    = ST_STOPPED;
            pc_d       = inflight_pc_q + 1'b1;
            inflight_d = 1'b0;
         end
`endif
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         state_q       <= ST_RUN;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         hold_ir_q     <= '0;
         hold_pc_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_ir_q[i] <= '0;
            mem_pc_q[i] <= '0;
         end
      end else begin
         pc_q          <= pc_d;
         state_q       <= state_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         hold_ir_q     <= hold_ir_d;
         hold_pc_q     <= hold_pc_d;
         mem_ir_q      <= mem_ir_d;
         mem_pc_q      <= mem_pc_d;
      end
   end

endmodule

// File: tb/tb_risc_fetch_unit.sv
// tb_risc_fetch_unit: directed bench for risc_fetch_unit. An instruction
// memory model answers every request one cycle later; delivered
// instructions are compared against an expected-PC queue, and cycle-exact
// behaviour (request timing, flush, halt, HLT stop) is checked directly.
module tb_risc_fetch_unit;
   localparam int WIDTH    = 32;
   localparam int ADDRSIZE = 12;
   localparam int DEPTH    = 4;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                imem_req;
   logic [ADDRSIZE-1:0] imem_addr;
   logic [WIDTH-1:0]    imem_rdata = '0;
   logic                redirect = 1'b0;
   logic [ADDRSIZE-1:0] redirect_pc = '0;
   logic                halt = 1'b0;
   logic                ir_valid;
   logic [WIDTH-1:0]    ir;
   logic [ADDRSIZE-1:0] ir_pc;
   logic                ir_ready = 1'b0;
   logic [ADDRSIZE-1:0] fetch_pc;

   int n_tests = 0;
   int n_fail  = 0;
   logic [ADDRSIZE-1:0] exp_q[$];
   logic hlt_en = 1'b0;
   int   reqs;

   risc_fetch_unit #(
      .WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE), .DEPTH(DEPTH), .RESET_PC(12'h000)
   ) u_dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready),
      .fetch_pc(fetch_pc)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // Memory contents: word k holds k, except an HLT at address 5 when enabled
   function automatic logic [WIDTH-1:0] mem_word(input logic [ADDRSIZE-1:0] a);
      if (hlt_en && a == 12'd5) return 32'h9000_0000;
      return 32'(a);
   endfunction

   // Instruction memory with fixed one-cycle read latency
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mem_word(imem_addr);
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard: every accepted instruction must be the next expected PC
   always @(negedge clk) begin
      if (ir_valid && ir_ready && !redirect && !reset) begin
         check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            automatic logic [ADDRSIZE-1:0] e = exp_q.pop_front();
            check("pop_pc", 32'(ir_pc), 32'(e));
            check("pop_ir", ir, mem_word(e));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Advance one cycle, apply this cycle's inputs, let outputs settle
   task automatic step(input logic rst_i, input logic rdy_i, input logic hlt_i,
                       input logic redir_i, input logic [ADDRSIZE-1:0] rpc_i);
      @(posedge clk);
      #1;
      reset       = rst_i;
      ir_ready    = rdy_i;
      halt        = hlt_i;
      redirect    = redir_i;
      redirect_pc = rpc_i;
      #1;
   endtask

   // Two reset cycles; returns inside the first cycle after reset drops
   task automatic do_reset(input logic rdy_i);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      step(1'b0, rdy_i, 1'b0, 1'b0, '0);
   endtask

   task automatic check_drained(input string tag);
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // Watchdog: the sequence is cycle-counted, this only guards against a hang
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      // Test 1: reset state, then streaming with ir_ready=1
      for (int p = 0; p < 6; p++) exp_q.push_back(ADDRSIZE'(p));
      do_reset(1'b1);
      check("rst_ir_valid", 32'(ir_valid), 32'd0);
      check("rst_ir", ir, 32'd0);
      check("rst_ir_pc", 32'(ir_pc), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
         check("t1_req", 32'(imem_req), 32'd1);
         check("t1_addr", 32'(imem_addr), 32'(k - 1));
         check("t1_fetch_pc", 32'(fetch_pc), 32'(k - 1));
         if (k < 3) begin
            check("t1_valid_lo", 32'(ir_valid), 32'd0);
         end else begin
            check("t1_valid_hi", 32'(ir_valid), 32'd1);
            check("t1_ir_pc", 32'(ir_pc), 32'(k - 3));
         end
      end

      // Test 2: backpressure fills exactly DEPTH entries, then drains in order
      do_reset(1'b0);
      check_drained("t1_drained");
      reqs = 0;
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
         reqs += int'(imem_req);
         if (k >= 3) begin
            check("t2_valid", 32'(ir_valid), 32'd1);
            check("t2_ir_hold", ir, 32'd0);
            check("t2_pc_hold", 32'(ir_pc), 32'd0);
         end
      end
      check("t2_req_count", 32'(reqs), 32'd4);
      check("t2_req_full", 32'(imem_req), 32'd0);
      for (int p = 0; p < 8; p++) exp_q.push_back(ADDRSIZE'(p));
      for (int k = 11; k <= 18; k++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, '0);
         check("t2_no_gap", 32'(ir_valid), 32'd1);
      end

      // Test 3: redirect with 3 queued + 1 in flight
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check_drained("t2_drained");
      check("t3_pre_req", 32'(imem_req), 32'd1);
      check("t3_pre_addr", 32'(imem_addr), 32'd11);
      step(1'b0, 1'b1, 1'b0, 1'b1, 12'h100);
      check("t3_redir_noreq", 32'(imem_req), 32'd0);
      for (int p = 0; p < 4; p++) exp_q.push_back(ADDRSIZE'(12'h100 + p));
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("t3_flush_valid", 32'(ir_valid), 32'd0);
      check("t3_flush_req", 32'(imem_req), 32'd1);
      check("t3_flush_addr", 32'(imem_addr), 32'h100);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("t3_c2_valid", 32'(ir_valid), 32'd0);
      check("t3_c2_addr", 32'(imem_addr), 32'h101);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("t3_first_valid", 32'(ir_valid), 32'd1);
      check("t3_first_pc", 32'(ir_pc), 32'h100);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);

      // Test 4: PC wrap from 0xFFE
      step(1'b0, 1'b1, 1'b0, 1'b1, 12'hFFE);
      check_drained("t3_drained");
      exp_q.push_back(12'hFFE);
      exp_q.push_back(12'hFFF);
      exp_q.push_back(12'h000);
      exp_q.push_back(12'h001);
      for (int j = 1; j <= 6; j++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, '0);
         if (j == 3) check("t4_wrap_addr", 32'(imem_addr), 32'h000);
      end

      // Test 5: halt for 5 cycles with one read in flight
      step(1'b0, 1'b1, 1'b0, 1'b1, 12'h040);
      check_drained("t4_drained");
      exp_q.push_back(12'h040);
      exp_q.push_back(12'h041);
      exp_q.push_back(12'h042);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("t5_issue", 32'(imem_addr), 32'h040);
      for (int j = 2; j <= 6; j++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, '0);
         check("t5_halt_noreq", 32'(imem_req), 32'd0);
         if (j == 3) begin
            check("t5_inflight_valid", 32'(ir_valid), 32'd1);
            check("t5_inflight_pc", 32'(ir_pc), 32'h040);
         end
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("t5_resume_req", 32'(imem_req), 32'd1);
      check("t5_resume_addr", 32'(imem_addr), 32'h041);
      for (int j = 8; j <= 10; j++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);

      // Redirect while halted: PC still moves, fetch waits for halt to drop
      step(1'b0, 1'b0, 1'b1, 1'b1, 12'h080);
      check_drained("t5_drained");
      check("t5_rh_noreq", 32'(imem_req), 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, '0);
      check("t5_rh_fetch_pc", 32'(fetch_pc), 32'h080);
      check("t5_rh_noreq2", 32'(imem_req), 32'd0);
      check("t5_rh_valid", 32'(ir_valid), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("t5_rh_req", 32'(imem_req), 32'd1);
      check("t5_rh_addr", 32'(imem_addr), 32'h080);

      // Test 6: HLT word at address 5
      hlt_en = 1'b1;
      step(1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
      for (int p = 0; p < 6; p++) exp_q.push_back(ADDRSIZE'(p));
`ifndef FETCH_HLT_STOP_EN
      exp_q.push_back(12'd6);
      exp_q.push_back(12'd7);
`endif
      for (int c = 1; c <= 10; c++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, '0);
         if (c <= 6) begin
            check("t6_req", 32'(imem_req), 32'd1);
            check("t6_addr", 32'(imem_addr), 32'(c - 1));
         end else begin
`ifdef FETCH_HLT_STOP_EN
            check("t6_stopped_noreq", 32'(imem_req), 32'd0);
`else
            check("t6_past_hlt_req", 32'(imem_req), 32'd1);
            check("t6_past_hlt_addr", 32'(imem_addr), 32'(c - 1));
`endif
         end
         if (c == 8) begin
            check("t6_hlt_pc", 32'(ir_pc), 32'd5);
            check("t6_hlt_ir", ir, 32'h9000_0000);
         end
`ifdef FETCH_HLT_STOP_EN
         if (c == 9) begin
            check("t6_stop_valid", 32'(ir_valid), 32'd0);
            check("t6_stop_fetch_pc", 32'(fetch_pc), 32'd6);
         end
`else
         if (c == 9) check("t6_next_pc", 32'(ir_pc), 32'd6);
`endif
      end
      step(1'b0, 1'b1, 1'b0, 1'b1, 12'h020);
      check_drained("t6_drained");
      exp_q.push_back(12'h020);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("t6_restart_req", 32'(imem_req), 32'd1);
      check("t6_restart_addr", 32'(imem_addr), 32'h020);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("t6_restart_pc", 32'(ir_pc), 32'h020);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check_drained("t6_final_drained");

      // ---------------- report ----------------
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
